ps2_transmitter: RTL and testbench
==================================

Name: ps2_transmitter

Overview:
- Host-to-device PS/2 sender; the counterpart to the PS/2 receiver on EXT_P[7]/EXT_P[4].
- Lets the CPU send keyboard commands such as LED set (0xED), enable (0xF4) and reset (0xFF).
- Drives clock and data open-drain through output-enable lines; the top level maps each to `oe ? 1'b0 : 1'bz`.
- Sits beside the receiver; `busy` gates the receiver's ps2_done/IRQ path while a transfer is in progress.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- INHIBIT_US, 100, time the clock line is held low before the request.
- REQ_US, 5, time data and clock are both held low before the clock is released.
- TIMEOUT_US, 15000, maximum gap between device clock falling edges before abort.
- FILTER_LEN, 8, consecutive equal samples needed to accept a new line level.

Ports:
- clk  in  1  system clock (CLK50MHz).
- res  in  1  asynchronous reset, active high.
- tx_data  in  8  byte to send; captured on an accepted tx_start.
- tx_start  in  1  one-cycle request; ignored while busy=1.
- ps2_clock  in  1  raw PS/2 clock pin level.
- ps2_data  in  1  raw PS/2 data pin level.
- clk_oe  out  1  1 = pull PS/2 clock low.
- dat_oe  out  1  1 = pull PS/2 data low.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse: transfer finished and device acknowledged.
- err_noack  out  1  one-cycle pulse: ack bit sampled high.
- err_timeout  out  1  one-cycle pulse: device clock gap exceeded TIMEOUT.

Behaviour:
- Reset (async, res=1):
  - clk_oe=0, dat_oe=0, busy=0, done=0, err_*=0, state=IDLE.
  - Both filters preset to 1.
  - Reset mid-transfer releases both lines immediately, with no partial byte.
- Line conditioning:
  - 2-flop synchroniser on each pin, then a FILTER_LEN-sample equality filter.
  - fall = filtered clock goes 1->0; this is a single-cycle strobe.
- Cycle counts: CYC(us) = CLK_HZ/1000000*us. Counter widths come from $clog2 of the largest count.
- Capture: on tx_start in IDLE, latch shift[7:0]=tx_data and par = ~^tx_data (odd parity). Set busy=1 on the next edge.
- FSM:
  - IDLE: all oe=0. On tx_start -> INHIBIT, counter cleared.
  - INHIBIT: clk_oe=1, dat_oe=0 for CYC(INHIBIT_US) cycles -> REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit) for CYC(REQ_US) cycles -> SEND, with clk_oe=0 and bitcnt=0.
  - SEND:
    - On each fall, bitcnt increments.
    - fall 1..8: dat_oe = ~shift[bitcnt-1], LSB first.
    - fall 9: dat_oe = ~par.
    - fall 10: dat_oe = 0 (stop bit / release) -> ACK.
  - ACK: on fall 11, sample filtered data. 0 -> WAIT_IDLE. 1 -> pulse err_noack, go IDLE.
  - WAIT_IDLE: wait until filtered clock=1 and data=1 -> pulse done, go IDLE.
- busy=1 in every state except IDLE. It drops in the same cycle as the done/err pulse.
- Timeout:
  - Counter runs in SEND, ACK and WAIT_IDLE; it clears on every fall.
  - Reaching CYC(TIMEOUT_US) releases both lines, pulses err_timeout, goes IDLE.
  - It has priority over a fall arriving in the same cycle.
- Data changes only on fall, never on rising clock edges; the device samples on rising edges.
- dat_oe is never asserted while filtered data is externally low in IDLE (host never contends in IDLE).
- tx_start asserted with busy=1: dropped, no queueing, no error.
- Exactly one of done/err_noack/err_timeout pulses per accepted tx_start.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE).
  - Frame constants: START_BITS=1, DATA_BITS=8, PAR_FALL=9, STOP_FALL=10, ACK_FALL=11.
  - Function for CYC(us).
- Sub-module ps2_line_filter (synchroniser + equality filter + fall strobe):
  - Instantiated twice (clock, data).
  - Reusable by the receiver.

Test Plan:
- Timing parameters for all scenarios: CLK_HZ=1000000, INHIBIT_US=100, REQ_US=5, TIMEOUT_US=2000.
- Device model: clocks at ~10 µs half-period, samples data on rising edges, drives ack low at fall 11.
- Scenarios:
  - tx_data=0xF4 -> clk_oe high for 100 cycles, then both low 5 cycles. Model sees start=0, bits 0,0,1,0,1,1,1,1, parity=0, stop=1. done pulses once, busy falls.
  - tx_data=0xED, then 0x02 after done -> parity bits 1 then 0. Two done pulses, no errors.
  - Model withholds ack (data high at fall 11) -> err_noack single pulse, no done, dat_oe=0, busy=0.
  - Model stops clocking after fall 4 -> err_timeout exactly 2000 cycles after fall 4. Lines released, busy=0.
  - tx_start pulsed again mid-frame with 0x55 -> ignored. Frame carries the original byte, only one done.
  - res asserted during SEND after fall 6 -> clk_oe=dat_oe=busy=0 asynchronously. A new tx_start after reset sends a full frame correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter and its line conditioning.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } state_e;

    localparam int unsigned START_BITS = 1;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned PAR_FALL   = 9;
    localparam int unsigned STOP_FALL  = 10;
    localparam int unsigned ACK_FALL   = 11;

    // Convert microseconds to system clock cycles.
    function automatic int unsigned cyc(input int unsigned clk_hz, input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-flop synchroniser, FILTER_LEN-sample equality filter and a falling-edge strobe.
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic res,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [1:0]            sync_q, sync_d;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  level_q, level_d;
    logic                  fall_q, fall_d;

    // A new level is accepted only once the whole history window agrees.
    always_comb begin
        sync_d  = {sync_q[0], pin};
        hist_d  = {hist_q[FILTER_LEN-2:0], sync_q[1]};
        level_d = level_q;
        if (&hist_q) begin
            level_d = 1'b1;
        end else if (~|hist_q) begin
            level_d = 1'b0;
        end
        fall_d = level_q & ~level_d;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sync_q  <= 2'b11;
            hist_q  <= '1;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            level_q <= level_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign fall  = fall_q;

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte sender driving clock/data open-drain via output enables.
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned INHIBIT_US = 100,
    parameter int unsigned REQ_US     = 5,
    parameter int unsigned TIMEOUT_US = 15000,
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       res,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    output logic       clk_oe,
    output logic       dat_oe,
    output logic       busy,
    output logic       done,
    output logic       err_noack,
    output logic       err_timeout
);

    localparam int unsigned INH_CYC = cyc(CLK_HZ, INHIBIT_US);
    localparam int unsigned REQ_CYC = cyc(CLK_HZ, REQ_US);
    localparam int unsigned TO_CYC  = cyc(CLK_HZ, TIMEOUT_US);
    localparam int unsigned MAX_A   = (INH_CYC > REQ_CYC) ? INH_CYC : REQ_CYC;
    localparam int unsigned MAX_CYC = (MAX_A > TO_CYC) ? MAX_A : TO_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
    localparam int unsigned BIT_W   = 4;

    logic clk_lvl, clk_fall, dat_lvl, dat_fall_unused;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk   (clk),
        .res   (res),
        .pin   (ps2_clock),
        .level (clk_lvl),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
        .clk   (clk),
        .res   (res),
        .pin   (ps2_data),
        .level (dat_lvl),
        .fall  (dat_fall_unused)
    );

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_q, par_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               noack_q, noack_d;
    logic               tmo_q, tmo_d;
    logic [BIT_W-1:0]   fall_n;
    logic [2:0]         data_idx;

    // Next-state and output logic; cnt_q doubles as phase timer and device-clock gap timer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        clk_oe_d = clk_oe_q;
        dat_oe_d = dat_oe_q;
        done_d   = 1'b0;
        noack_d  = 1'b0;
        tmo_d    = 1'b0;
        fall_n   = bit_q + BIT_W'(1);
        data_idx = 3'(fall_n - BIT_W'(START_BITS));

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    shift_d  = tx_data;
                    par_d    = ~^tx_data;
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INH_CYC - 1)) begin
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REQ: begin
                if (cnt_q == CNT_W'(REQ_CYC - 1)) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    clk_oe_d = 1'b0;
                    state_d  = SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SEND, ACK, WAIT_IDLE: begin
                // Gap timeout wins over a fall landing in the same cycle.
                if (cnt_q == CNT_W'(TO_CYC - 1)) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    tmo_d    = 1'b1;
                    state_d  = IDLE;
                end else begin
                    cnt_d = clk_fall ? CNT_W'(1) : cnt_q + CNT_W'(1);
                    if (state_q == SEND && clk_fall) begin
                        bit_d = fall_n;
                        if (fall_n <= BIT_W'(DATA_BITS)) begin
                            dat_oe_d = ~shift_q[data_idx];
                        end else if (fall_n == BIT_W'(PAR_FALL)) begin
                            dat_oe_d = ~par_q;
                        end else begin
                            dat_oe_d = 1'b0;
                            state_d  = ACK;
                        end
                    end
                    if (state_q == ACK && clk_fall && fall_n == BIT_W'(ACK_FALL)) begin
                        bit_d = fall_n;
                        if (dat_lvl) begin
                            noack_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = WAIT_IDLE;
                        end
                    end
                    if (state_q == WAIT_IDLE && clk_lvl && dat_lvl) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            noack_q  <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            noack_q  <= noack_d;
            tmo_q    <= tmo_d;
        end
    end

    assign clk_oe      = clk_oe_q;
    assign dat_oe      = dat_oe_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_noack   = noack_q;
    assign err_timeout = tmo_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: behavioural PS/2 device, outcome scoreboard and a decoupled pulse monitor.
module tb_ps2_transmitter;

    localparam int unsigned CLK_HZ     = 1_000_000;
    localparam int unsigned INHIBIT_US = 100;
    localparam int unsigned REQ_US     = 5;
    localparam int unsigned TIMEOUT_US = 2000;
    localparam int unsigned FILTER_LEN = 4;
    // Raw pin edge to fall strobe: 2 sync flops + FILTER_LEN history + level register.
    localparam int FALL_LAT = 2 + int'(FILTER_LEN) + 1;
    localparam int K_DONE   = 0;
    localparam int K_NOACK  = 1;
    localparam int K_TO     = 2;

    logic       clk = 1'b0;
    logic       res;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk, dev_dat;
    logic       ps2_clock, ps2_data;
    logic       clk_oe, dat_oe, busy, done, err_noack, err_timeout;

    assign ps2_clock = dev_clk & ~clk_oe;
    assign ps2_data  = dev_dat & ~dat_oe;

    ps2_transmitter #(
        .CLK_HZ     (CLK_HZ),
        .INHIBIT_US (INHIBIT_US),
        .REQ_US     (REQ_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_LEN (FILTER_LEN)
    ) dut (
        .clk         (clk),
        .res         (res),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .ps2_clock   (ps2_clock),
        .ps2_data    (ps2_data),
        .clk_oe      (clk_oe),
        .dat_oe      (dat_oe),
        .busy        (busy),
        .done        (done),
        .err_noack   (err_noack),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t        sb_q[$];
    int          checks    = 0;
    int          failures  = 0;
    int          evt_cnt   = 0;
    int          evt_cyc   = 0;
    int          cyc_count = 0;
    int          fall_cyc  = 0;
    logic [10:0] rx_bits   = '1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
    endtask

    task automatic push(input int kind, input logic [7:0] d, input logic p);
        exp_t e;
        e.kind = kind;
        e.data = d;
        e.par  = p;
        sb_q.push_back(e);
    endtask

    // Device: times inhibit/request, then clocks nfalls falling edges, sampling on rising edges.
    task automatic dev_run(input int nfalls, input bit ack);
        int n;
        n = 0;
        while (clk_oe !== 1'b1 && n < 50) begin tick(1); n++; end
        chk("req_seen", int'(clk_oe), 1);
        n = 0;
        while (clk_oe === 1'b1 && dat_oe === 1'b0 && n < 1000) begin tick(1); n++; end
        chk("inhibit_len", n, 100);
        n = 0;
        while (clk_oe === 1'b1 && dat_oe === 1'b1 && n < 1000) begin tick(1); n++; end
        chk("req_len", n, 5);
        chk("clk_released", int'(clk_oe), 0);
        rx_bits    = '1;
        rx_bits[0] = ps2_data;
        tick(10);
        for (int k = 1; k <= nfalls; k++) begin
            if (k == 11 && ack) begin
                dev_dat = 1'b0;
                tick(5);
            end
            dev_clk  = 1'b0;
            fall_cyc = cyc_count;
            tick(10);
            dev_clk = 1'b1;
            if (k <= 10) rx_bits[k] = ps2_data;
            if (k == 11) dev_dat = 1'b1;
            tick(10);
        end
    endtask

    task automatic wait_evt(input int n0, input int budget);
        int i;
        i = 0;
        while (evt_cnt == n0 && i < budget) begin tick(1); i++; end
        chk("outcome_seen", int'(evt_cnt != n0), 1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc_count++;
        end
    end

    // Monitor: every done/err pulse is matched against the oldest expected outcome.
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || err_noack === 1'b1 || err_timeout === 1'b1) begin
                evt_cnt++;
                evt_cyc = cyc_count;
                chk("pulse_onehot", int'(done) + int'(err_noack) + int'(err_timeout), 1);
                k = (done === 1'b1) ? K_DONE : ((err_noack === 1'b1) ? K_NOACK : K_TO);
                chk("busy_at_pulse", int'(busy), 0);
                chk("lines_at_pulse", int'({clk_oe, dat_oe}), 0);
                if (sb_q.size() == 0) begin
                    chk("unexpected_pulse", k, -1);
                end else begin
                    e = sb_q.pop_front();
                    chk("outcome_kind", k, e.kind);
                    if (e.kind == K_DONE && k == K_DONE) begin
                        chk("rx_start", int'(rx_bits[0]), 0);
                        chk("rx_byte", int'(rx_bits[8:1]), int'(e.data));
                        chk("rx_parity", int'(rx_bits[9]), int'(e.par));
                        chk("rx_stop", int'(rx_bits[10]), 1);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        res      = 1'b1;
        tx_data  = 8'h00;
        tx_start = 1'b0;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        tick(3);
        chk("reset_outputs", int'({clk_oe, dat_oe, busy, done, err_noack, err_timeout}), 0);
        res = 1'b0;
        tick(5);

        // Enable command 0xF4: odd parity bit 0.
        n0 = evt_cnt;
        push(K_DONE, 8'hF4, 1'b0);
        send(8'hF4);
        chk("busy_after_start", int'(busy), 1);
        dev_run(11, 1'b1);
        wait_evt(n0, 200);

        // LED set 0xED (parity 1) then its argument 0x02 (parity 0).
        n0 = evt_cnt;
        push(K_DONE, 8'hED, 1'b1);
        send(8'hED);
        dev_run(11, 1'b1);
        wait_evt(n0, 200);
        n0 = evt_cnt;
        push(K_DONE, 8'h02, 1'b0);
        send(8'h02);
        dev_run(11, 1'b1);
        wait_evt(n0, 200);

        // Device withholds the acknowledge.
        tick(20);
        n0 = evt_cnt;
        push(K_NOACK, 8'hF4, 1'b0);
        send(8'hF4);
        dev_run(11, 1'b0);
        wait_evt(n0, 200);

        // Device stops clocking after fall 4.
        tick(20);
        n0 = evt_cnt;
        push(K_TO, 8'hED, 1'b1);
        send(8'hED);
        dev_run(4, 1'b1);
        wait_evt(n0, 3000);
        chk("timeout_latency", evt_cyc - fall_cyc, FALL_LAT + 2000);

        // Second tx_start mid-frame must be dropped.
        tick(20);
        n0 = evt_cnt;
        push(K_DONE, 8'hFF, 1'b1);
        send(8'hFF);
        fork
            dev_run(11, 1'b1);
            begin
                tick(200);
                send(8'h55);
            end
        join
        wait_evt(n0, 200);
        tick(50);
        chk("single_outcome", evt_cnt - n0, 1);

        // Asynchronous reset after fall 6, then a clean frame.
        n0 = evt_cnt;
        send(8'h02);
        dev_run(6, 1'b1);
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_dat_oe", int'(dat_oe), 1);
        res = 1'b1;
        #1;
        chk("async_reset_lines", int'({clk_oe, dat_oe, busy}), 0);
        tick(2);
        res = 1'b0;
        tick(5);
        chk("no_pulse_on_reset", evt_cnt - n0, 0);
        n0 = evt_cnt;
        push(K_DONE, 8'hF4, 1'b0);
        send(8'hF4);
        dev_run(11, 1'b1);
        wait_evt(n0, 200);

        tick(20);
        chk("sb_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
